// File: rtl/xram_arb_pkg.sv
// Shared definitions for the two-port XRAM arbiter.
//   arb_state_e   : arbiter state encoding (IDLE=0, BUSY=1)
//   PORT_CPU/AES  : requester index constants (8051 core = 0, AES = 1)
//   TIMEOUT_DATA  : read data returned on a watchdog abort
//   port_onehot() : requester index -> one-hot grant vector
package xram_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam logic       PORT_CPU     = 1'b0;
    localparam logic       PORT_AES     = 1'b1;
    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

    function automatic logic [1:0] port_onehot(input logic port);
        if (port == PORT_AES) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

endpackage

// File: rtl/xram_arb_watchdog.sv
// Watchdog for outstanding XRAM strobes.
// Only instantiated when XRAM_ARB_TIMEOUT_EN is defined.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : arbiter is entering BUSY on the next edge (clears the count)
//   busy      : arbiter is in BUSY this cycle
//   xram_ack  : XRAM completion this cycle
//   expire    : this BUSY cycle is the TIMEOUT-th one without an acknowledge
module xram_arb_watchdog #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    input  logic xram_ack,
    output logic expire
);

    logic [7:0] count_r;

    // Count completed BUSY cycles that passed without an XRAM acknowledge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= 8'd0;
        end else if (start) begin
            count_r <= 8'd0;
        end else if (busy && !xram_ack) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // count_r holds the silent cycles before this one, so the current cycle
    // is the TIMEOUT-th silent cycle when count_r equals TIMEOUT-1.
    assign expire = busy && !xram_ack && (count_r == (TIMEOUT - 8'd1));

endmodule

// File: rtl/xram_arbiter.sv
// Round-robin arbiter sharing the single-ported XRAM between the 8051 core
// (port 0) and the AES accelerator (port 1). One transaction is latched into
// the xram_* registers, run as a single strobe/ack exchange, and its ack and
// read data are routed back to the winning port only.
// Optional feature macro: XRAM_ARB_TIMEOUT_EN (watchdog abort + sticky err).
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   pN_addr/wdata/wr/stb     : requester N transaction, held until pN_ack
//   pN_ack, pN_rdata         : completion pulse and read data for requester N
//   xram_addr/data_out/wr/stb: registered XRAM request
//   xram_data_in, xram_ack   : XRAM response
//   grant                    : one-hot current owner, 00 when idle
//   err, err_clr             : sticky timeout flag and its synchronous clear
module xram_arbiter
    import xram_arb_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    input  logic        p0_wr,
    input  logic        p0_stb,
    output logic        p0_ack,
    output logic [7:0]  p0_rdata,
    input  logic [15:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    input  logic        p1_wr,
    input  logic        p1_stb,
    output logic        p1_ack,
    output logic [7:0]  p1_rdata,
    output logic [15:0] xram_addr,
    output logic [7:0]  xram_data_out,
    output logic        xram_wr,
    output logic        xram_stb,
    input  logic [7:0]  xram_data_in,
    input  logic        xram_ack,
    output logic [1:0]  grant,
    output logic        err,
    input  logic        err_clr
);

    arb_state_e state_r;
    logic       last_r;
    logic       req_any_s;
    logic       winner_s;
    logic       expire_s;
    logic       done_s;
    logic [7:0] resp_data_s;

    assign req_any_s = p0_stb | p1_stb;

    // Pick the next owner: the port that did not go last wins a tie
    always_comb begin
        if (p0_stb && p1_stb) begin
            winner_s = ~last_r;
        end else if (p1_stb) begin
            winner_s = PORT_AES;
        end else begin
            winner_s = PORT_CPU;
        end
    end

    // A transaction ends on the XRAM ack or on a watchdog abort
    assign done_s = (state_r == ST_BUSY) && (xram_ack || expire_s);

    // Arbitration FSM; the xram_* registers load only when leaving IDLE,
    // so they stay stable for the whole BUSY period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            last_r        <= PORT_AES;
            grant         <= 2'b00;
            xram_addr     <= 16'h0000;
            xram_data_out <= 8'h00;
            xram_wr       <= 1'b0;
            xram_stb      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        xram_addr     <= (winner_s == PORT_AES) ? p1_addr  : p0_addr;
                        xram_data_out <= (winner_s == PORT_AES) ? p1_wdata : p0_wdata;
                        xram_wr       <= (winner_s == PORT_AES) ? p1_wr    : p0_wr;
                        grant         <= port_onehot(winner_s);
                        xram_stb      <= 1'b1;
                        state_r       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done_s) begin
                        last_r   <= grant[1];
                        grant    <= 2'b00;
                        xram_stb <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    grant    <= 2'b00;
                    xram_stb <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Abort returns a fixed pattern instead of whatever the XRAM drives
    always_comb begin
        if (expire_s) begin
            resp_data_s = TIMEOUT_DATA;
        end else begin
            resp_data_s = xram_data_in;
        end
    end

    // Ack and data go to the owner only, and only in the completion cycle
    assign p0_ack   = done_s & grant[0];
    assign p1_ack   = done_s & grant[1];
    assign p0_rdata = p0_ack ? resp_data_s : 8'h00;
    assign p1_rdata = p1_ack ? resp_data_s : 8'h00;

`ifdef XRAM_ARB_TIMEOUT_EN
    logic start_s;
    logic busy_s;
    logic err_r;

    assign start_s = (state_r == ST_IDLE) && req_any_s;
    assign busy_s  = (state_r == ST_BUSY);

    xram_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s),
        .busy     (busy_s),
        .xram_ack (xram_ack),
        .expire   (expire_s)
    );

    // Sticky timeout flag; a new timeout takes priority over a clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (expire_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    logic [8:0] unused_s;

    assign expire_s = 1'b0;
    assign err      = 1'b0;
    assign unused_s = {err_clr, TIMEOUT};
`endif

endmodule

// File: tb/tb_xram_arbiter.sv
// Self-checking bench for xram_arbiter: a memory-backed XRAM responder with
// random latency, two requesters, and a transaction-level reference model of
// the round-robin rule. Timeout scenarios run when XRAM_ARB_TIMEOUT_EN is set.
module tb_xram_arbiter;

    localparam logic [7:0] TO = 8'd4;

    logic        clk;
    logic        rst;
    logic [15:0] p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata;
    logic        p0_wr, p1_wr, p0_stb, p1_stb, p0_ack, p1_ack;
    logic [7:0]  p0_rdata, p1_rdata;
    logic [15:0] xram_addr;
    logic [7:0]  xram_data_out, xram_data_in;
    logic        xram_wr, xram_stb, xram_ack;
    logic [1:0]  grant;
    logic        err, err_clr;

    xram_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wr(p0_wr), .p0_stb(p0_stb),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wr(p1_wr), .p1_stb(p1_stb),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .xram_addr(xram_addr), .xram_data_out(xram_data_out), .xram_wr(xram_wr),
        .xram_stb(xram_stb), .xram_data_in(xram_data_in), .xram_ack(xram_ack),
        .grant(grant), .err(err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // requesters
    bit          req_v [2];
    logic [15:0] req_addr [2];
    bit          req_wr [2];
    logic [7:0]  req_wd [2];
    int          gen_mode;   // 0 directed, 1 random arrivals, 2 always requesting

    // XRAM responder and reference memory
    logic [7:0]  xmem [65536];
    logic [7:0]  ref_mem [65536];
    bit          r_act;
    int          r_lat;
    int          resp_mode;  // 0 random latency, 1 never ack, 2 ack in 4th cycle

    // reference model
    bit          exp_busy, done_prev, to_prev, exp_err;
    int          exp_owner, exp_last, busy_cyc;

    // observations
    int          obs_ack [2];
    int          obs_busy;
    logic [7:0]  last_rd [2];
    logic [1:0]  prev_grant_obs;
    logic [1:0]  grant_seq [$];

    task automatic drive_pins();
        p0_stb = req_v[0]; p0_addr = req_addr[0]; p0_wr = req_wr[0]; p0_wdata = req_wd[0];
        p1_stb = req_v[1]; p1_addr = req_addr[1]; p1_wr = req_wr[1]; p1_wdata = req_wd[1];
    endtask

    task automatic set_req(input int n, input logic [15:0] a, input bit w, input logic [7:0] d);
        req_v[n] = 1'b1; req_addr[n] = a; req_wr[n] = w; req_wd[n] = d;
        drive_pins();
    endtask

    task automatic new_req(input int n);
        logic [15:0] a;
        a = {($urandom_range(0, 1) == 1) ? 8'h12 : 8'h00, 8'h40 + 8'($urandom_range(0, 7))};
        req_v[n] = 1'b1; req_addr[n] = a;
        req_wr[n] = ($urandom_range(0, 1) == 1); req_wd[n] = 8'($urandom);
    endtask

    task automatic reset_model();
        exp_busy = 1'b0; exp_last = 1; exp_err = 1'b0; exp_owner = 0;
        done_prev = 1'b0; to_prev = 1'b0; busy_cyc = 0;
        r_act = 1'b0; prev_grant_obs = 2'b00;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_grant"}, grant, 2'b00);
        check_eq({tag, "_xstb"}, xram_stb, 1'b0);
        check_eq({tag, "_xwr"}, xram_wr, 1'b0);
        check_eq({tag, "_xaddr"}, xram_addr, 16'h0000);
        check_eq({tag, "_xdout"}, xram_data_out, 8'h00);
        check_eq({tag, "_p0ack"}, p0_ack, 1'b0);
        check_eq({tag, "_p1ack"}, p1_ack, 1'b0);
        check_eq({tag, "_p0rd"}, p0_rdata, 8'h00);
        check_eq({tag, "_p1rd"}, p1_rdata, 8'h00);
        check_eq({tag, "_err"}, err, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b0; xram_ack = 1'b0; err_clr = 1'b0;
        reset_model();
        #1;
        check_zero("rst");
        repeat (2) begin
            @(negedge clk);
            p0_stb = ~p0_stb; p1_stb = ~p1_stb; p0_addr = 16'($urandom);
            #1;
            check_zero("rst_tog");
        end
        @(negedge clk);
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        drive_pins();
        rst = 1'b1;
    endtask

    // One clock: update the model for the edge just passed, answer as XRAM,
    // check every output, then let the requesters move.
    task automatic cycle();
        bit pstb0, pstb1, pclr, tmo, fin, e_ack, o_ack;
        logic [7:0] e_rd, o_rd;
        logic [1:0] e_grant;
        pstb0 = p0_stb; pstb1 = p1_stb; pclr = err_clr;
        @(negedge clk);
        if (!exp_busy) begin
            if (pstb0 && pstb1) begin
                exp_owner = 1 - exp_last; exp_busy = 1'b1; busy_cyc = 0;
            end else if (pstb0 || pstb1) begin
                exp_owner = pstb0 ? 0 : 1; exp_busy = 1'b1; busy_cyc = 0;
            end
        end else if (done_prev) begin
            exp_busy = 1'b0; exp_last = exp_owner;
        end
        if (to_prev) exp_err = 1'b1;
        else if (pclr) exp_err = 1'b0;
        done_prev = 1'b0; to_prev = 1'b0;
        if (exp_busy) busy_cyc++;

        xram_ack = 1'b0;
        xram_data_in = 8'($urandom);
        if (xram_stb) begin
            if (!r_act) begin
                r_act = 1'b1;
                r_lat = (resp_mode == 0) ? $urandom_range(0, 3) : 3;
            end
            if (resp_mode != 1) begin
                if (r_lat == 0) begin
                    xram_ack = 1'b1; r_act = 1'b0;
                    if (xram_wr) xmem[xram_addr] = xram_data_out;
                    else xram_data_in = xmem[xram_addr];
                end else begin
                    r_lat--;
                end
            end
        end else begin
            r_act = 1'b0;
        end
        #1;

        e_grant = !exp_busy ? 2'b00 : (exp_owner == 0) ? 2'b01 : 2'b10;
        check_eq("grant", grant, e_grant);
        check_eq("xram_stb", xram_stb, exp_busy);
        if (exp_busy) begin
            check_eq("xram_addr", xram_addr, req_addr[exp_owner]);
            check_eq("xram_wr", xram_wr, req_wr[exp_owner]);
            if (req_wr[exp_owner]) check_eq("xram_dout", xram_data_out, req_wd[exp_owner]);
        end
        tmo = 1'b0;
`ifdef XRAM_ARB_TIMEOUT_EN
        tmo = exp_busy && !xram_ack && (busy_cyc == int'(TO));
`endif
        fin = exp_busy && (xram_ack || tmo);
        for (int n = 0; n < 2; n++) begin
            e_ack = fin && (exp_owner == n);
            if (!e_ack) e_rd = 8'h00;
            else if (tmo) e_rd = 8'hFF;
            else if (req_wr[n]) e_rd = xram_data_in;
            else e_rd = ref_mem[req_addr[n]];
            o_ack = (n == 0) ? p0_ack : p1_ack;
            o_rd = (n == 0) ? p0_rdata : p1_rdata;
            check_eq((n == 0) ? "p0_ack" : "p1_ack", o_ack, e_ack);
            check_eq((n == 0) ? "p0_rdata" : "p1_rdata", o_rd, e_rd);
            if (o_ack) begin obs_ack[n]++; last_rd[n] = o_rd; end
        end
        check_eq("err", err, exp_err);
        if (xram_stb) obs_busy++;
        if (grant != 2'b00 && prev_grant_obs == 2'b00) grant_seq.push_back(grant);
        prev_grant_obs = grant;

        if (fin) begin
            if (!tmo && req_wr[exp_owner]) ref_mem[req_addr[exp_owner]] = req_wd[exp_owner];
            done_prev = 1'b1; to_prev = tmo;
            req_v[exp_owner] = 1'b0;
        end
        for (int n = 0; n < 2; n++) begin
            if (!req_v[n]) begin
                if (gen_mode == 2) new_req(n);
                else if (gen_mode == 1 && $urandom_range(0, 1) == 1) new_req(n);
            end
        end
        drive_pins();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((req_v[0] || req_v[1] || exp_busy || done_prev) && k < budget) begin
            cycle();
            k++;
        end
        check_eq("drain_budget", {31'd0, (req_v[0] || req_v[1] || exp_busy)}, 32'd0);
    endtask

    task automatic wait_acks(input int n, input int target, input int budget);
        int k;
        k = 0;
        while (obs_ack[n] < target && k < budget) begin
            cycle();
            k++;
        end
        check_eq("ack_wait_budget", obs_ack[n], target);
    endtask

    initial begin
        logic [1:0] exp_seq [4];
        int k;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        rst = 1'b1; err_clr = 1'b0; xram_ack = 1'b0; xram_data_in = 8'h00;
        gen_mode = 0; resp_mode = 0; obs_busy = 0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; req_addr[i] = 16'h0000; req_wr[i] = 1'b0; req_wd[i] = 8'h00;
            obs_ack[i] = 0; last_rd[i] = 8'h00;
        end
        drive_pins();
        for (int i = 0; i < 65536; i++) begin
            xmem[i] = i[7:0] ^ i[15:8];
            ref_mem[i] = i[7:0] ^ i[15:8];
        end
        #2;
        apply_reset();

        // first request: strobe one cycle after stb is sampled
        set_req(0, 16'h1234, 1'b0, 8'h00);
        cycle();
        check_eq("first_stb", xram_stb, 1'b1);
        check_eq("first_addr", xram_addr, 16'h1234);
        check_eq("first_grant", grant, 2'b01);
        drain(50);

        // p1 write then read back
        obs_ack[0] = 0; obs_ack[1] = 0;
        set_req(1, 16'h0040, 1'b1, 8'hA5);
        drain(50);
        check_eq("wr_p1_acks", obs_ack[1], 1);
        check_eq("wr_p0_acks", obs_ack[0], 0);
        set_req(1, 16'h0040, 1'b0, 8'h00);
        drain(50);
        check_eq("rd_p1_acks", obs_ack[1], 2);
        check_eq("rd_p0_acks", obs_ack[0], 0);
        check_eq("rd_p1_data", last_rd[1], 8'hA5);

        // continuous contention from reset
        apply_reset();
        obs_ack[0] = 0; obs_ack[1] = 0; grant_seq.delete();
        new_req(0); new_req(1); drive_pins();
        gen_mode = 2;
        k = 0;
        while (obs_ack[0] + obs_ack[1] < 4 && k < 200) begin
            cycle();
            k++;
        end
        gen_mode = 0;
        check_eq("cont_total_acks", obs_ack[0] + obs_ack[1], 4);
        check_eq("cont_p0_acks", obs_ack[0], 2);
        check_eq("cont_p1_acks", obs_ack[1], 2);
        for (int i = 0; i < 4; i++) begin
            check_eq("cont_grant_seq", (i < grant_seq.size()) ? grant_seq[i] : 2'b11, exp_seq[i]);
        end
        drain(50);

        // reset in the middle of a transaction
        resp_mode = 1;
        set_req(1, 16'h0041, 1'b1, 8'h3C);
        k = 0;
        while (!exp_busy && k < 10) begin
            cycle();
            k++;
        end
        check_eq("midrst_busy", xram_stb, 1'b1);
        #1 rst = 1'b0;
        #1;
        check_eq("midrst_xstb", xram_stb, 1'b0);
        check_eq("midrst_grant", grant, 2'b00);
        check_eq("midrst_p0ack", p0_ack, 1'b0);
        check_eq("midrst_p1ack", p1_ack, 1'b0);
        reset_model();
        @(negedge clk);
        rst = 1'b1; resp_mode = 0;
        set_req(0, 16'h0043, 1'b0, 8'h00);
        cycle();
        check_eq("midrst_regrant", grant, 2'b01);
        drain(50);

`ifdef XRAM_ARB_TIMEOUT_EN
        // XRAM never answers: abort after TO busy cycles
        resp_mode = 1; obs_busy = 0; obs_ack[0] = 0;
        set_req(0, 16'h0042, 1'b0, 8'h00);
        wait_acks(0, 1, 20);
        check_eq("to_rdata", last_rd[0], 8'hFF);
        check_eq("to_busy_cycles", obs_busy, 4);
        cycle();
        check_eq("to_err_set", err, 1'b1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check_eq("to_err_clr", err, 1'b0);

        // ack exactly at the limit completes normally
        resp_mode = 2; obs_busy = 0; obs_ack[1] = 0;
        set_req(1, 16'h0040, 1'b0, 8'h00);
        wait_acks(1, 1, 20);
        check_eq("lim_rdata", last_rd[1], ref_mem[16'h0040]);
        check_eq("lim_busy_cycles", obs_busy, 4);
        cycle();
        check_eq("lim_err", err, 1'b0);
        resp_mode = 0;
`endif

        // random traffic
        gen_mode = 1; resp_mode = 0;
        repeat (1500) cycle();
        gen_mode = 0;
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xram_arbiter.md
# xram_arbiter

Two-port arbiter sharing the single-ported `oc8051_xram` between the 8051 core's external-memory port (port 0) and the AES accelerator's XRAM master port (port 1). It sits between both masters and the XRAM model in the top-level integration. It latches one winner's request, runs one strobe/ack transaction on the XRAM side, and returns ack and read data to that winner only. Arbitration is round-robin; an optional watchdog aborts transactions that are never acknowledged.

## Interface
- `TIMEOUT`, 255, watchdog limit in cycles of outstanding `xram_stb` (8-bit counter; legal 1..255)
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `p0_addr` / `p1_addr`  in  16  requester address
- `p0_wdata` / `p1_wdata`  in  8  requester write data
- `p0_wr` / `p1_wr`  in  1  1 = write, 0 = read
- `p0_stb` / `p1_stb`  in  1  request strobe, held with addr/wr/wdata until ack
- `p0_ack` / `p1_ack`  out  1  one-cycle completion pulse
- `p0_rdata` / `p1_rdata`  out  8  read data, valid in ack cycle
- `xram_addr`  out  16  registered address to XRAM
- `xram_data_out`  out  8  registered write data to XRAM
- `xram_wr`  out  1  registered write enable
- `xram_stb`  out  1  registered strobe (also drives XRAM rd_en/wr_en)
- `xram_data_in`  in  8  XRAM read data
- `xram_ack`  in  1  XRAM completion
- `grant`  out  2  one-hot current owner; 00 when idle
- `err`  out  1  sticky timeout flag
- `err_clr`  in  1  synchronous clear of `err`

## Operation
- States: IDLE, BUSY.
- IDLE: if either `pN_stb` is high, select a winner, latch its addr/wdata/wr into the `xram_*` registers, set `grant`, set `xram_stb` = 1, go BUSY. Neither high: stay.
- Round-robin: a `last` bit holds the most recent owner. On contention, the port ≠ `last` wins. A lone requester always wins. After reset, `last` = 1, so port 0 wins the first contention.
- BUSY, `xram_ack` = 1:
  - `pN_ack` = 1 for the owner (combinational from `xram_ack` & `grant`).
  - `pN_rdata` = `xram_data_in` for the owner.
  - Next edge: `xram_stb` = 0, `grant` = 00, `last` = owner, state IDLE.
- Non-owner ack is always 0. Non-owner rdata is always 00; owner rdata outside the ack cycle is 00.
- A requester dropping `stb` before ack is a protocol violation. The latched transaction still completes and the ack pulse is still issued.
- Writes return rdata = `xram_data_in` (don't-care to the master).
- `err_clr` clears `err` on the next edge. A timeout in the same cycle sets it instead (set wins).

## Timing
- Reset (`rst` low, asynchronous): state IDLE, `xram_addr`/`xram_data_out` = 0, `xram_wr`/`xram_stb` = 0, `grant` = 00, `last` = 1, `err` = 0, watchdog = 0. `pN_ack` = 0 and `pN_rdata` = 00 follow immediately.
- Reset mid-BUSY abandons the transaction: no ack is issued and the XRAM strobe drops at once.
- Arbitration latency: `pN_stb` sampled high at edge k gives `xram_stb` high after edge k.
- Ack latency: 0 cycles added after `xram_ack`. Total = 1 + XRAM latency.
- One idle cycle always separates back-to-back transactions. With both requesting continuously, grants alternate 0,1,0,1.
- The `xram_*` outputs are stable for the whole BUSY period.

## Configuration
- `XRAM_ARB_TIMEOUT_EN` defined:
  - An 8-bit watchdog clears on entering BUSY and increments each BUSY cycle without `xram_ack`.
  - When it reaches `TIMEOUT` with `xram_ack` low, the arbiter pulses the owner's ack with rdata = 8'hFF, sets `err`, drops `xram_stb`, and returns to IDLE. `last` updates as for a normal completion.
  - `xram_ack` in the same cycle as the limit is a normal completion; `err` is not set.
- Not defined: no watchdog logic. `err` is tied 0 and `err_clr` is ignored. BUSY waits for `xram_ack` indefinitely.

## Structure
- Shared package `xram_arb_pkg`: state encoding (IDLE=0, BUSY=1), port index constants (CPU=0, AES=1), timeout data constant 8'hFF.
- One natural sub-module, `xram_arb_watchdog`: the counter plus compare, instantiated only under `XRAM_ARB_TIMEOUT_EN`.

## Test plan
- Reset: hold `rst` low, toggle both stb → all outputs 0, `grant` = 00. Release `rst`, then `p0_stb` with addr 16'h1234 → `xram_stb` is 1 one cycle later.
- Single write then read: p1 writes 8'hA5 to 16'h0040 → `p1_ack` pulses once and `p0_ack` stays 0. p1 reads 16'h0040 → `p1_rdata` = 8'hA5 in the ack cycle.
- Contention: both stb high from reset for 4 transactions → grant sequence 01,10,01,10. Each port sees exactly 2 acks with the correct data.
- Reset mid-BUSY: assert `rst` while `xram_stb` = 1 → `xram_stb` = 0 immediately, no ack issued. The next contention grants port 0.
- Timeout (macro on, TIMEOUT = 4): XRAM never acks → owner ack arrives 4 BUSY cycles in with rdata 8'hFF and `err` = 1. `err_clr` → `err` = 0 next cycle.
- Ack at limit (macro on, TIMEOUT = 4): `xram_ack` arrives in the 4th BUSY cycle → normal rdata, `err` stays 0.
